// File: rtl/ltu_pkg.sv
// ltu_pkg: shared types and constants for the tick profile sequencer.
// Holds the FSM state encoding, default widths and slot reset values.
package ltu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SETTLE,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int DEF_CW = 8;
    localparam int DEF_TW = 8;

    // A programmed tick count of zero runs the segment for this many ticks.
    localparam int TICKS_MIN = 1;

    localparam int RESET_RATE  = 1;
    localparam int RESET_TICKS = 1;

endpackage

// File: rtl/tick_profile_sequencer_if.sv
// tick_profile_sequencer_if: control-side and generator-side signals.
// The master drives config/control and generator status; the slave is the sequencer.
interface tick_profile_sequencer_if
    import ltu_pkg::*;
#(
    parameter int NSEG = 4,
    parameter int CW   = DEF_CW,
    parameter int TW   = DEF_TW
);
    localparam int AW = $clog2(NSEG);

    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_max_cnt;
    logic [TW-1:0] cfg_ticks;
    logic [AW-1:0] last_seg;
    logic          loop;
    logic          start;
    logic          abort;
    logic          gen_stable;
    logic          gen_tick;
    logic          gen_enable;
    logic [CW-1:0] gen_max_cnt;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] cur_seg;

    modport master (
        output cfg_we, cfg_addr, cfg_max_cnt, cfg_ticks,
        output last_seg, loop, start, abort,
        output gen_stable, gen_tick,
        input  gen_enable, gen_max_cnt, busy, done, err, cur_seg
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_max_cnt, cfg_ticks,
        input  last_seg, loop, start, abort,
        input  gen_stable, gen_tick,
        output gen_enable, gen_max_cnt, busy, done, err, cur_seg
    );

endinterface

// File: rtl/seg_regfile.sv
// seg_regfile: NSEG slots of {rate, ticks}, sync write, async read.
// A write to the slot being read is forwarded so a same-cycle start sees it.
module seg_regfile
    import ltu_pkg::*;
#(
    parameter int NSEG = 4,
    parameter int CW   = DEF_CW,
    parameter int TW   = DEF_TW,
    localparam int AW  = $clog2(NSEG)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wrate,
    input  logic [TW-1:0] wticks,
    input  logic [AW-1:0] raddr,
    output logic [CW-1:0] rrate,
    output logic [TW-1:0] rticks
);

    logic [CW-1:0] rate_q  [NSEG];
    logic [TW-1:0] ticks_q [NSEG];

    // Slot storage; every slot resets to rate 1, ticks 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSEG; i++) begin
                rate_q[i]  <= CW'(RESET_RATE);
                ticks_q[i] <= TW'(RESET_TICKS);
            end
        end else if (we) begin
            rate_q[waddr]  <= wrate;
            ticks_q[waddr] <= wticks;
        end
    end

    // Read port with write-first forwarding.
    always_comb begin
        rrate  = rate_q[raddr];
        rticks = ticks_q[raddr];
        if (we && (waddr == raddr)) begin
            rrate  = wrate;
            rticks = wticks;
        end
    end

endmodule

// File: rtl/tick_profile_sequencer.sv
// tick_profile_sequencer: steps the tick generator through a profile.
// Each segment sets max_cnt, waits for stable, then counts its ticks.
module tick_profile_sequencer
    import ltu_pkg::*;
#(
    parameter int NSEG      = 4,
    parameter int CW        = DEF_CW,
    parameter int TW        = DEF_TW,
    parameter int SETTLE_TO = 16
) (
    input logic                    clk,
    input logic                    reset_n,
    tick_profile_sequencer_if.slave bus
);

    localparam int AW  = $clog2(NSEG);
    localparam int TOW = $clog2(SETTLE_TO + 1);

    state_t        state_q, state_d;
    logic [AW-1:0] seg_q, seg_d;
    logic [CW-1:0] rate_q;
    logic [TW-1:0] cnt_q;
    logic [TOW-1:0] to_q;
    logic          err_q;
    logic          live_q;
    logic          loop_q;
    logic [AW-1:0] last_q;

    logic          rate_ld, cnt_ld, cnt_dec, live_clr;
    logic          err_set, err_clr, cfg_ld;
    logic          busy_w;
    logic [CW-1:0] rd_rate;
    logic [TW-1:0] rd_ticks, eff_ticks;

    assign busy_w = (state_q == ST_BLANK) || (state_q == ST_SETTLE)
                 || (state_q == ST_RUN);

    assign eff_ticks = (rd_ticks == '0) ? TW'(TICKS_MIN) : rd_ticks;

    // Read address follows the segment being entered, so rates load on the edge.
    seg_regfile #(
        .NSEG (NSEG),
        .CW   (CW),
        .TW   (TW)
    ) u_regs (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (bus.cfg_we && !busy_w),
        .waddr   (bus.cfg_addr),
        .wrate   (bus.cfg_max_cnt),
        .wticks  (bus.cfg_ticks),
        .raddr   (seg_d),
        .rrate   (rd_rate),
        .rticks  (rd_ticks)
    );

    // Next-state and datapath controls; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        rate_ld  = 1'b0;
        cnt_ld   = 1'b0;
        cnt_dec  = 1'b0;
        live_clr = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        cfg_ld   = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            err_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (bus.start) begin
                        state_d  = ST_BLANK;
                        seg_d    = '0;
                        rate_ld  = 1'b1;
                        live_clr = 1'b1;
                        err_clr  = 1'b1;
                        cfg_ld   = 1'b1;
                    end
                end
                ST_BLANK: begin
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (bus.gen_stable) begin
                        state_d = ST_RUN;
                        cnt_ld  = !live_q;
                    end else if (to_q == TOW'(SETTLE_TO - 1)) begin
                        state_d = ST_ERR;
                        err_set = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!bus.gen_stable) begin
                        state_d = ST_BLANK;
                    end else if (bus.gen_tick) begin
                        cnt_dec = 1'b1;
                        if (cnt_q == TW'(1)) begin
                            live_clr = 1'b1;
                            if (seg_q != last_q) begin
                                seg_d   = seg_q + 1'b1;
                                rate_ld = 1'b1;
                                state_d = ST_BLANK;
                            end else if (loop_q) begin
                                seg_d   = '0;
                                rate_ld = 1'b1;
                                state_d = ST_BLANK;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            seg_q   <= '0;
            rate_q  <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
            loop_q  <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            if (rate_ld) begin
                rate_q <= rd_rate;
            end
            if (cnt_ld) begin
                cnt_q <= eff_ticks;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (live_clr) begin
                live_q <= 1'b0;
            end else if (cnt_ld) begin
                live_q <= 1'b1;
            end
            if (state_q == ST_SETTLE) begin
                to_q <= to_q + 1'b1;
            end else begin
                to_q <= '0;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            if (cfg_ld) begin
                last_q <= bus.last_seg;
                loop_q <= bus.loop;
            end
        end
    end

    assign bus.gen_enable  = busy_w;
    assign bus.gen_max_cnt = rate_q;
    assign bus.busy        = busy_w;
    assign bus.done        = (state_q == ST_DONE);
    assign bus.err         = err_q;
    assign bus.cur_seg     = seg_q;

endmodule

// File: tb/tb_tick_profile_sequencer.sv
// tb_tick_profile_sequencer: directed profiles with a cycle-stamped scoreboard.
// Each output change is popped and compared against the expected snapshot.
module tb_tick_profile_sequencer;

    typedef struct {
        int          cyc;
        logic [13:0] v;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    ev_t  sb[$];

    tick_profile_sequencer_if #(.NSEG(4), .CW(8), .TW(8)) bus ();

    tick_profile_sequencer #(
        .NSEG      (4),
        .CW        (8),
        .TW        (8),
        .SETTLE_TO (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic s, input logic k, input int n = 1);
        for (int i = 0; i < n; i++) begin
            bus.gen_stable = s;
            bus.gen_tick   = k;
            step();
        end
    endtask

    task automatic wr(input int a, input int r, input int t);
        bus.cfg_we      = 1'b1;
        bus.cfg_addr    = a[1:0];
        bus.cfg_max_cnt = r[7:0];
        bus.cfg_ticks   = t[7:0];
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic ex(input int c, input logic b, input logic en,
                      input int mc, input int seg,
                      input logic d, input logic er);
        ev_t e;
        e.cyc = c;
        e.v   = {b, en, mc[7:0], seg[1:0], d, er};
        sb.push_back(e);
    endtask

    // Monitor: pop and compare on every change of the output snapshot.
    initial begin
        logic [13:0] snap;
        logic [13:0] prev;
        bit          first;
        ev_t         e;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clk);
            snap = {bus.busy, bus.gen_enable, bus.gen_max_cnt,
                    bus.cur_seg, bus.done, bus.err};
            if (first || (snap != prev)) begin
                first = 1'b0;
                prev  = snap;
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event cyc=%0d got=%h exp=none",
                             cyc, snap);
                end else begin
                    e = sb.pop_front();
                    if ((snap != e.v) || ((e.cyc >= 0) && (e.cyc != cyc))) begin
                        n_bad++;
                        $display("FAIL event cyc=%0d got=%h exp=%h exp_cyc=%0d",
                                 cyc, snap, e.v, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_max_cnt = 0;
        bus.cfg_ticks = 0; bus.last_seg = 0; bus.loop = 0;
        bus.start = 0; bus.abort = 0; bus.gen_stable = 0; bus.gen_tick = 0;
        ex(-1, 0, 0, 0, 0, 0, 0);
        #1 reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        // Two segments {3,2},{1,3}; a tick during SETTLE is ignored.
        wr(0, 3, 2);
        wr(1, 1, 3);
        bus.last_seg = 2'd1;
        t = cyc;
        ex(t + 1, 1, 1, 3, 0, 0, 0);
        ex(t + 6, 1, 1, 1, 1, 0, 0);
        ex(t + 12, 0, 0, 1, 1, 1, 0);
        ex(t + 13, 0, 0, 1, 1, 0, 0);
        bus.start = 1; drv(0, 0); bus.start = 0;
        drv(0, 0);
        drv(1, 0);
        drv(1, 1);
        drv(1, 0);
        drv(1, 1);
        drv(0, 0, 2);
        drv(1, 1, 4);
        drv(0, 0, 3);

        // Looping profile, four segment ends, then abort mid-RUN.
        bus.loop = 1;
        t = cyc;
        ex(t + 1, 1, 1, 3, 0, 0, 0);
        ex(t + 5, 1, 1, 1, 1, 0, 0);
        ex(t + 10, 1, 1, 3, 0, 0, 0);
        ex(t + 14, 1, 1, 1, 1, 0, 0);
        ex(t + 19, 1, 1, 3, 0, 0, 0);
        ex(t + 23, 0, 0, 3, 0, 0, 0);
        bus.start = 1; drv(1, 1); bus.start = 0;
        drv(1, 1, 21);
        bus.abort = 1; drv(1, 1); bus.abort = 0;
        bus.loop = 0;
        drv(0, 0, 4);

        // Settle timeout, restart clears err, abort; start+abort is ignored.
        bus.last_seg = 2'd0;
        t = cyc;
        ex(t + 1, 1, 1, 3, 0, 0, 0);
        ex(t + 18, 0, 0, 3, 0, 0, 1);
        ex(t + 21, 1, 1, 3, 0, 0, 0);
        ex(t + 22, 0, 0, 3, 0, 0, 0);
        bus.start = 1; drv(0, 0); bus.start = 0;
        drv(0, 0, 19);
        bus.start = 1; drv(0, 0); bus.start = 0;
        bus.abort = 1; drv(0, 0); bus.abort = 0;
        drv(0, 0, 2);
        bus.start = 1; bus.abort = 1; drv(0, 0);
        bus.start = 0; bus.abort = 0;
        drv(0, 0, 3);

        // Write-first on start, ticks 0 behaves as one tick.
        t = cyc;
        ex(t + 1, 1, 1, 5, 0, 0, 0);
        ex(t + 4, 0, 0, 5, 0, 1, 0);
        ex(t + 5, 0, 0, 5, 0, 0, 0);
        bus.cfg_we = 1; bus.cfg_addr = 0;
        bus.cfg_max_cnt = 8'd5; bus.cfg_ticks = 8'd0;
        bus.start = 1; drv(0, 0);
        bus.start = 0; bus.cfg_we = 0;
        drv(0, 0);
        drv(1, 0);
        drv(1, 1);
        drv(0, 0, 3);

        // Re-settle keeps 2 remaining ticks; write while busy is dropped.
        wr(0, 7, 4);
        wr(1, 0, 1);
        bus.last_seg = 2'd1;
        t = cyc;
        ex(t + 1, 1, 1, 7, 0, 0, 0);
        ex(t + 10, 1, 1, 0, 1, 0, 0);
        ex(t + 13, 0, 0, 0, 1, 1, 0);
        ex(t + 14, 0, 0, 0, 1, 0, 0);
        bus.start = 1; drv(0, 0); bus.start = 0;
        drv(0, 0);
        drv(1, 0);
        drv(1, 1, 2);
        bus.cfg_we = 1; bus.cfg_addr = 1;
        bus.cfg_max_cnt = 8'd9; bus.cfg_ticks = 8'd9;
        drv(0, 0);
        bus.cfg_we = 0;
        drv(0, 0);
        drv(1, 0);
        drv(1, 1, 2);
        drv(0, 0);
        drv(1, 0);
        drv(1, 1);
        drv(0, 0, 3);

        // Async reset mid-RUN, then slot 0 back to rate 1, ticks 1.
        t = cyc;
        ex(t + 1, 1, 1, 7, 0, 0, 0);
        ex(t + 4, 0, 0, 0, 0, 0, 0);
        bus.start = 1; drv(0, 0); bus.start = 0;
        drv(0, 0);
        drv(1, 0);
        drv(1, 1);
        reset_n = 1'b0;
        bus.gen_stable = 0; bus.gen_tick = 0;
        step();
        reset_n = 1'b1;
        step();
        bus.last_seg = 2'd0;
        t = cyc;
        ex(t + 1, 1, 1, 1, 0, 0, 0);
        ex(t + 4, 0, 0, 1, 0, 1, 0);
        ex(t + 5, 0, 0, 1, 0, 0, 0);
        bus.start = 1; drv(0, 0); bus.start = 0;
        drv(0, 0);
        drv(1, 0);
        drv(1, 1);
        drv(0, 0, 5);

        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events got=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
